apb_req_master: RTL and testbench
=================================

// Module: apb_req_master
// PURPOSE
// - Parametrised APB4 requester: converts a valid/ready command port into APB SETUP/ACCESS transfers.
// - Supports wait states (pready), pslverr, byte strobes, pprot and a programmable ACCESS-phase timeout.
// - Sits between the test/system-side command source and one APB completer (or APB decoder).
// - Returns a one-cycle response pulse per transfer.
// PARAMETERS
// - ADDR_W       32  paddr / req_addr width
// - DATA_W       32  data width; must be 8, 16 or 32
// - TIMEOUT_CYC  16  max ACCESS cycles with pready low before abort; 0 = timeout disabled
// PORTS
// - pclk         in   1         clock, all logic on rising edge
// - prst_n       in   1         asynchronous active-low reset
// - req_valid    in   1         command valid
// - req_ready    out  1         command accepted when req_valid & req_ready
// - req_write    in   1         1 = write, 0 = read
// - req_addr     in   ADDR_W    transfer address
// - req_wdata    in   DATA_W    write data
// - req_strb     in   DATA_W/8  write byte strobes
// - req_prot     in   3         pprot value
// - rsp_valid    out  1         one-cycle response pulse
// - rsp_rdata    out  DATA_W    read data (0 for writes and timeouts)
// - rsp_err      out  1         pslverr seen, or timeout
// - rsp_timeout  out  1         transfer aborted by timeout
// - psel, penable, pwrite  out 1; paddr out ADDR_W; pwdata out DATA_W; pstrb out DATA_W/8; pprot out 3
// - pready in 1; prdata in DATA_W; pslverr in 1
// BEHAVIOUR
// - Reset (async, prst_n low): every output 0, FSM to IDLE, timeout counter 0; an in-flight transfer is dropped, no rsp.
// - FSM: IDLE -> SETUP -> ACCESS -> IDLE. All outputs registered.
// - IDLE: req_ready=1, psel=0, penable=0. On req_valid: register addr/write/prot; pwdata=req_wdata and
//   pstrb=req_strb for writes, pwdata=0 and pstrb=0 for reads; go SETUP.
// - SETUP (exactly 1 cycle): psel=1, penable=0, req_ready=0; go ACCESS.
// - ACCESS: psel=1, penable=1; paddr/pwrite/pwdata/pstrb/pprot held stable until exit.
//   - pready=1: complete. Next cycle rsp_valid=1, rsp_err=pslverr, rsp_timeout=0,
//     rsp_rdata=prdata for reads (sampled that edge), 0 for writes; go IDLE.
//   - pready=0: wait; counter increments each waited cycle.
//   - TIMEOUT_CYC>0 and counter reaches TIMEOUT_CYC with pready still 0: abort; next cycle
//     rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0; psel/penable drop to 0; go IDLE.
//   - pready=1 in the same cycle the timeout would fire: completion wins, no timeout.
// - Counter: width $clog2(TIMEOUT_CYC+1) (min 1); cleared on entry to SETUP; never wraps (saturates).
// - On return to IDLE paddr/pwrite/pwdata/pstrb/pprot keep last values; psel/penable are 0.
// - rsp_* fields hold after the pulse until the next response; only rsp_valid is a pulse.
// - Throughput: min 3 cycles per transfer (IDLE accept, SETUP, ACCESS); req_ready low from SETUP to rsp.
// - pslverr, prdata are ignored unless psel & penable & pready.
// - Requests presented while req_ready=0 are not accepted; the source must hold them.
// TESTING
// - Write 0x0000_0010 <- 0xDEAD_BEEF, strb 4'hF, pready=1: SETUP 1 cyc, ACCESS 1 cyc; rsp_valid, err=0.
// - Read 0x24, pready low 3 cycles then high with prdata 0x1234_5678: ACCESS 4 cyc, paddr stable; rsp_rdata=0x1234_5678.
// - Write with pslverr=1 at completion: rsp_err=1, rsp_timeout=0; read: pstrb=0, pwdata=0 throughout.
// - TIMEOUT_CYC=4, pready held low: abort after 4 waited cycles, rsp_err=1, rsp_timeout=1, rdata=0, psel=0.
// - pready rises on the exact timeout cycle: normal completion; TIMEOUT_CYC=0 with 100 waits: no abort.
// - prst_n low mid-ACCESS: all outputs 0 asynchronously, no rsp_valid; next request runs normally.

Source files
------------

// File: rtl/apb_req_master.sv
// APB4 requester: turns a valid/ready command into one SETUP/ACCESS transfer
// and reports the outcome as a one-cycle response pulse.
module apb_req_master #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                pclk,
    input  logic                prst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_strb,
    input  logic [2:0]          req_prot,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                rsp_timeout,
    output logic                psel,
    output logic                penable,
    output logic                pwrite,
    output logic [ADDR_W-1:0]   paddr,
    output logic [DATA_W-1:0]   pwdata,
    output logic [DATA_W/8-1:0] pstrb,
    output logic [2:0]          pprot,
    input  logic                pready,
    input  logic [DATA_W-1:0]   prdata,
    input  logic                pslverr
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CW     = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam bit TO_EN  = (TIMEOUT_CYC > 0);
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_e;

    state_e              state_q;
    logic [CW-1:0]       cnt_q;
    logic [CW-1:0]       cnt_d;
    logic                to_hit;
    logic                done;

    logic                req_ready_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                rsp_err_q;
    logic                rsp_timeout_q;
    logic                psel_q;
    logic                penable_q;
    logic                pwrite_q;
    logic [ADDR_W-1:0]   paddr_q;
    logic [DATA_W-1:0]   pwdata_q;
    logic [STRB_W-1:0]   pstrb_q;
    logic [2:0]          pprot_q;

    // Saturating wait counter next value and timeout detection for this cycle
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != '1) begin
            cnt_d = cnt_q + CW'(1);
        end
        done   = psel_q && penable_q && pready;
        to_hit = TO_EN && (cnt_d == TO_VAL);
    end

    // Transfer FSM; every APB and response output is registered here
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            req_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            pprot_q       <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    psel_q      <= 1'b0;
                    penable_q   <= 1'b0;
                    req_ready_q <= 1'b1;
                    if (req_valid && req_ready_q) begin
                        paddr_q     <= req_addr;
                        pwrite_q    <= req_write;
                        pprot_q     <= req_prot;
                        pwdata_q    <= req_write ? req_wdata : '0;
                        pstrb_q     <= req_write ? req_strb : '0;
                        psel_q      <= 1'b1;
                        req_ready_q <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (done) begin
                        rsp_valid_q   <= 1'b1;
                        rsp_err_q     <= pslverr;
                        rsp_timeout_q <= 1'b0;
                        rsp_rdata_q   <= pwrite_q ? '0 : prdata;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        req_ready_q   <= 1'b1;
                        state_q       <= IDLE;
                    end else if (to_hit) begin
                        rsp_valid_q   <= 1'b1;
                        rsp_err_q     <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        rsp_rdata_q   <= '0;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        req_ready_q   <= 1'b1;
                        cnt_q         <= cnt_d;
                        state_q       <= IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign pstrb       = pstrb_q;
    assign pprot       = pprot_q;

endmodule

// File: tb/tb_apb_req_master.sv
// Directed bench for apb_req_master: one task per scenario, inline checks.
// A second instance with the timeout disabled covers the long-wait case.
module tb_apb_req_master;

    logic        pclk;
    logic        prst_n;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_strb;
    logic [2:0]  req_prot;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;

    logic        req_valid0;
    logic        pready0;
    logic        req_ready0;
    logic        rsp_valid0;
    logic [31:0] rsp_rdata0;
    logic        rsp_err0;
    logic        rsp_timeout0;
    logic        psel0;
    logic        penable0;
    logic        pwrite0;
    logic [31:0] paddr0;
    logic [31:0] pwdata0;
    logic [3:0]  pstrb0;
    logic [2:0]  pprot0;

    int checks = 0;
    int errors = 0;

    apb_req_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(4)) dut (
        .pclk(pclk), .prst_n(prst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    apb_req_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(0)) dut0 (
        .pclk(pclk), .prst_n(prst_n),
        .req_valid(req_valid0), .req_ready(req_ready0),
        .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
        .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0),
        .rsp_err(rsp_err0), .rsp_timeout(rsp_timeout0),
        .psel(psel0), .penable(penable0), .pwrite(pwrite0),
        .paddr(paddr0), .pwdata(pwdata0), .pstrb(pstrb0), .pprot(pprot0),
        .pready(pready0), .prdata(prdata), .pslverr(pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] flags;
        prst_n = 1'b0;
        tick();
        flags = {req_ready, rsp_valid, rsp_err, rsp_timeout,
                 psel, penable, pwrite, 1'b0};
        checks++;
        if (flags !== 8'h00) begin
            errors++;
            $display("FAIL reset_flags: got %h want 00", flags);
        end
        checks++;
        if ({paddr, pwdata, rsp_rdata} !== 96'h0 || pstrb !== 4'h0 || pprot !== 3'h0) begin
            errors++;
            $display("FAIL reset_bus: paddr %h pwdata %h rdata %h strb %h prot %h want 0",
                     paddr, pwdata, rsp_rdata, pstrb, pprot);
        end
        prst_n = 1'b1;
        tick();
        checks++;
        if (req_ready !== 1'b1 || req_ready0 !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b/%b want 1/1", req_ready, req_ready0);
        end
    endtask

    task automatic test_write();
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h0000_0010;
        req_wdata = 32'hDEAD_BEEF;
        req_strb  = 4'hF;
        req_prot  = 3'b010;
        pready    = 1'b1;
        pslverr   = 1'b0;
        tick();
        req_valid = 1'b0;
        checks++;
        if ({psel, penable, pwrite, req_ready} !== 4'b1010 || paddr !== 32'h10 ||
            pwdata !== 32'hDEAD_BEEF || pstrb !== 4'hF || pprot !== 3'b010) begin
            errors++;
            $display("FAIL wr_setup: sel/en/wr/rdy %b%b%b%b addr %h data %h strb %h prot %h",
                     psel, penable, pwrite, req_ready, paddr, pwdata, pstrb, pprot);
        end
        tick();
        checks++;
        if ({psel, penable, rsp_valid} !== 3'b110) begin
            errors++;
            $display("FAIL wr_access: sel/en/rsp %b%b%b want 110", psel, penable, rsp_valid);
        end
        tick();
        checks++;
        if ({rsp_valid, rsp_err, rsp_timeout, psel, penable, req_ready} !== 6'b100001 ||
            rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL wr_rsp: v/e/t/sel/en/rdy %b%b%b%b%b%b rdata %h want 100001 0",
                     rsp_valid, rsp_err, rsp_timeout, psel, penable, req_ready, rsp_rdata);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || paddr !== 32'h10 || pwdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL wr_idle: rsp_valid %b addr %h data %h want 0 10 deadbeef",
                     rsp_valid, paddr, pwdata);
        end
    endtask

    task automatic test_read_wait();
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h0000_0024;
        req_wdata = 32'hFFFF_FFFF;
        req_strb  = 4'hF;
        req_prot  = 3'b001;
        pready    = 1'b0;
        prdata    = 32'hBAD0_BAD0;
        tick();
        req_valid = 1'b0;
        req_addr  = 32'h0000_0099;
        checks++;
        if (pwdata !== 32'h0 || pstrb !== 4'h0 || pwrite !== 1'b0) begin
            errors++;
            $display("FAIL rd_setup: pwdata %h pstrb %h pwrite %b want 0 0 0",
                     pwdata, pstrb, pwrite);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({psel, penable, rsp_valid} !== 3'b110 || paddr !== 32'h24 ||
                pwdata !== 32'h0 || pstrb !== 4'h0) begin
                errors++;
                $display("FAIL rd_wait%0d: sel/en/rsp %b%b%b addr %h data %h strb %h",
                         i, psel, penable, rsp_valid, paddr, pwdata, pstrb);
            end
            tick();
        end
        pready = 1'b1;
        prdata = 32'h1234_5678;
        tick();
        pready = 1'b0;
        prdata = 32'h0;
        checks++;
        if ({rsp_valid, rsp_err, rsp_timeout, psel} !== 4'b1000 ||
            rsp_rdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL rd_rsp: v/e/t/sel %b%b%b%b rdata %h want 1000 12345678",
                     rsp_valid, rsp_err, rsp_timeout, psel, rsp_rdata);
        end
    endtask

    task automatic test_slverr();
        tick();
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h0000_0040;
        req_wdata = 32'h0000_00AA;
        req_strb  = 4'h1;
        pready    = 1'b1;
        pslverr   = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        pslverr = 1'b0;
        checks++;
        if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b110 || pstrb !== 4'h1) begin
            errors++;
            $display("FAIL slverr_rsp: v/e/t %b%b%b strb %h want 110 1",
                     rsp_valid, rsp_err, rsp_timeout, pstrb);
        end
        tick();
        checks++;
        if ({rsp_valid, rsp_err} !== 2'b01) begin
            errors++;
            $display("FAIL slverr_hold: v/e %b%b want 01", rsp_valid, rsp_err);
        end
    endtask

    task automatic test_back_to_back();
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h0000_0100;
        req_wdata = 32'h1111_1111;
        req_strb  = 4'hF;
        pready    = 1'b1;
        tick();
        tick();
        tick();
        req_addr  = 32'h0000_0104;
        req_wdata = 32'h2222_2222;
        checks++;
        if (rsp_valid !== 1'b1 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_rsp1: rsp_valid %b req_ready %b want 1 1", rsp_valid, req_ready);
        end
        tick();
        req_valid = 1'b0;
        checks++;
        if ({psel, penable} !== 2'b10 || paddr !== 32'h104 || pwdata !== 32'h2222_2222) begin
            errors++;
            $display("FAIL b2b_setup2: sel/en %b%b addr %h data %h want 10 104 22222222",
                     psel, penable, paddr, pwdata);
        end
        tick();
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_rsp2: rsp_valid %b err %b want 1 0", rsp_valid, rsp_err);
        end
    endtask

    task automatic test_timeout();
        tick();
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h0000_0200;
        pready    = 1'b0;
        prdata    = 32'hAAAA_5555;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        tick();
        tick();
        checks++;
        if ({psel, penable, rsp_valid} !== 3'b110) begin
            errors++;
            $display("FAIL to_wait3: sel/en/rsp %b%b%b want 110", psel, penable, rsp_valid);
        end
        tick();
        checks++;
        if ({rsp_valid, rsp_err, rsp_timeout, psel, penable} !== 5'b11100 ||
            rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL to_abort: v/e/t/sel/en %b%b%b%b%b rdata %h want 11100 0",
                     rsp_valid, rsp_err, rsp_timeout, psel, penable, rsp_rdata);
        end
    endtask

    task automatic test_timeout_race();
        tick();
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h0000_0300;
        pready    = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        tick();
        tick();
        pready = 1'b1;
        prdata = 32'h0000_0055;
        tick();
        pready = 1'b0;
        checks++;
        if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b100 || rsp_rdata !== 32'h55) begin
            errors++;
            $display("FAIL to_race: v/e/t %b%b%b rdata %h want 100 55",
                     rsp_valid, rsp_err, rsp_timeout, rsp_rdata);
        end
    endtask

    task automatic test_no_timeout();
        int seen;
        seen       = 0;
        req_valid0 = 1'b1;
        req_write  = 1'b0;
        req_addr   = 32'h0000_0400;
        pready0    = 1'b0;
        prdata     = 32'h0000_0077;
        tick();
        req_valid0 = 1'b0;
        tick();
        for (int i = 0; i < 100; i++) begin
            if (rsp_valid0 !== 1'b0 || psel0 !== 1'b1 || penable0 !== 1'b1) seen++;
            tick();
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL notimeout_wait: %0d bad cycles want 0", seen);
        end
        pready0 = 1'b1;
        tick();
        pready0 = 1'b0;
        checks++;
        if ({rsp_valid0, rsp_err0, rsp_timeout0} !== 3'b100 || rsp_rdata0 !== 32'h77) begin
            errors++;
            $display("FAIL notimeout_rsp: v/e/t %b%b%b rdata %h want 100 77",
                     rsp_valid0, rsp_err0, rsp_timeout0, rsp_rdata0);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        seen      = 0;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h0000_0500;
        req_wdata = 32'hCAFE_F00D;
        pready    = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        #2;
        prst_n = 1'b0;
        #1;
        checks++;
        if ({psel, penable, pwrite, req_ready, rsp_valid} !== 5'b0 ||
            paddr !== 32'h0 || pwdata !== 32'h0 || pstrb !== 4'h0) begin
            errors++;
            $display("FAIL rst_async: sel/en/wr/rdy/rsp %b%b%b%b%b addr %h data %h strb %h",
                     psel, penable, pwrite, req_ready, rsp_valid, paddr, pwdata, pstrb);
        end
        tick();
        prst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (rsp_valid !== 1'b0) seen++;
            tick();
        end
        checks++;
        if (seen !== 0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_norsp: rsp cycles %0d ready %b want 0 1", seen, req_ready);
        end
        req_valid = 1'b1;
        req_addr  = 32'h0000_0600;
        req_wdata = 32'h0BAD_CAFE;
        pready    = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        checks++;
        if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b100 || paddr !== 32'h600) begin
            errors++;
            $display("FAIL rst_after: v/e/t %b%b%b addr %h want 100 600",
                     rsp_valid, rsp_err, rsp_timeout, paddr);
        end
    endtask

    initial begin
        prst_n     = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_strb   = '0;
        req_prot   = '0;
        pready     = 1'b0;
        prdata     = '0;
        pslverr    = 1'b0;
        req_valid0 = 1'b0;
        pready0    = 1'b0;
        #3;
        test_reset();
        test_write();
        test_read_wait();
        test_slverr();
        test_back_to_back();
        test_timeout();
        test_timeout_race();
        test_no_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
